// File: rtl/rob_pkg.sv
// Shared types and helpers for the n-port reorder buffer.
// Entry field widths are fixed here; the top's width parameters must match them.
package rob_pkg;

  localparam int unsigned RobAddrW = 5;
  localparam int unsigned RobDataW = 32;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic                w;
    logic [RobAddrW-1:0] addr;
    logic [RobDataW-1:0] data;
  } rob_entry_t;

  // Distance of id from head in allocation order; depth must be a power of two.
  function automatic logic [31:0] rob_age(input logic [31:0] id, input logic [31:0] head,
                                          input logic [31:0] depth);
    return (id - head) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/rob_nport_lookup.sv
// Age-ordered operand lookup: youngest allocated entry writing the requested register wins.
module rob_lookup
  import rob_pkg::*;
#(
  parameter int unsigned ID_SIZE          = 3,
  parameter int unsigned REG_ADDRESS_SIZE = RobAddrW,
  parameter int unsigned REGISTER_SIZE    = RobDataW
) (
  input  rob_entry_t                  entries [2**ID_SIZE],
  input  logic [ID_SIZE-1:0]          head,
  input  logic [ID_SIZE:0]            count,
  input  logic [REG_ADDRESS_SIZE-1:0] addr,
  output logic                        hit,
  output logic                        ready,
  output logic [ID_SIZE-1:0]          id,
  output logic [REGISTER_SIZE-1:0]    data
);

  localparam int unsigned DEPTH = 2**ID_SIZE;

  logic [ID_SIZE-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overwrites an earlier one.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    id    = '0;
    data  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + ID_SIZE'(i);
      if ((i < 32'(count)) && entries[idx].valid && entries[idx].w &&
          (entries[idx].addr == addr)) begin
        hit   = 1'b1;
        ready = entries[idx].done;
        id    = idx;
        data  = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/rob_nport.sv
// Reorder buffer: in-order alloc, out-of-order multi-port write-back, single in-order retire,
// selective flush for branch recovery and age-ordered operand lookup.
module rob_nport
  import rob_pkg::*;
#(
  parameter int unsigned ID_SIZE          = 3,
  parameter int unsigned N_PORTS          = 2,
  parameter int unsigned N_LOOKUP         = 2,
  parameter int unsigned REG_ADDRESS_SIZE = RobAddrW,
  parameter int unsigned REGISTER_SIZE    = RobDataW
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 alloc_req,
  input  logic                                 alloc_w,
  input  logic [REG_ADDRESS_SIZE-1:0]          alloc_addr,
  output logic [ID_SIZE-1:0]                   alloc_id,
  output logic                                 alloc_stall,
  input  logic [N_PORTS-1:0]                   wb_req,
  input  logic [N_PORTS*ID_SIZE-1:0]           wb_id,
  input  logic [N_PORTS*REGISTER_SIZE-1:0]     wb_data,
  output logic [N_PORTS-1:0]                   wb_stall,
  input  logic                                 flush,
  input  logic [ID_SIZE-1:0]                   flush_id,
  input  logic [N_LOOKUP*REG_ADDRESS_SIZE-1:0] lk_addr,
  output logic [N_LOOKUP-1:0]                  lk_hit,
  output logic [N_LOOKUP-1:0]                  lk_ready,
  output logic [N_LOOKUP*ID_SIZE-1:0]          lk_id,
  output logic [N_LOOKUP*REGISTER_SIZE-1:0]    lk_data,
  output logic                                 commit_valid,
  output logic                                 commit_we,
  output logic [REG_ADDRESS_SIZE-1:0]          commit_addr,
  output logic [REGISTER_SIZE-1:0]             commit_data
);

  localparam int unsigned DEPTH = 2**ID_SIZE;

  logic [ID_SIZE-1:0] head_q, head_d, tail_q, tail_d, wid;
  logic [ID_SIZE:0]   count_q, count_d;
  rob_entry_t         entries_q [DEPTH];
  rob_entry_t         entries_d [DEPTH];
  logic               alloc_fire, commit_fire;
  logic [31:0]        flush_age;

  assign alloc_id    = tail_q;
  assign alloc_stall = (count_q == (ID_SIZE+1)'(DEPTH)) | flush;

  // A port yields to any lower port targeting the same entry this cycle.
  always_comb begin
    wb_stall = '0;
    for (int unsigned p = 1; p < N_PORTS; p++) begin
      for (int unsigned q = 0; q < p; q++) begin
        if (wb_req[q] && (wb_id[q*ID_SIZE +: ID_SIZE] == wb_id[p*ID_SIZE +: ID_SIZE])) begin
          wb_stall[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    entries_d   = entries_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    wid         = '0;
    alloc_fire  = alloc_req & ~alloc_stall;
    commit_fire = entries_q[head_q].valid & entries_q[head_q].done;
    flush_age   = rob_age(32'(flush_id), 32'(head_q), 32'(DEPTH));

    for (int unsigned p = 0; p < N_PORTS; p++) begin
      wid = wb_id[p*ID_SIZE +: ID_SIZE];
      if (wb_req[p] && !wb_stall[p] && entries_q[wid].valid &&
          !(flush && (rob_age(32'(wid), 32'(head_q), 32'(DEPTH)) > flush_age))) begin
        entries_d[wid].data = wb_data[p*REGISTER_SIZE +: REGISTER_SIZE];
        entries_d[wid].done = 1'b1;
      end
    end

    if (commit_fire) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + 1'b1;
    end

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rob_age(i, 32'(head_q), 32'(DEPTH)) > flush_age) begin
          entries_d[ID_SIZE'(i)].valid = 1'b0;
        end
      end
      tail_d  = flush_id + 1'b1;
      count_d = (ID_SIZE+1)'(flush_age + 32'd1 - 32'(commit_fire));
    end else begin
      if (alloc_fire) begin
        entries_d[tail_q].valid = 1'b1;
        entries_d[tail_q].done  = 1'b0;
        entries_d[tail_q].w     = alloc_w;
        entries_d[tail_q].addr  = alloc_addr;
      end
      tail_d  = tail_q + ID_SIZE'(alloc_fire);
      count_d = count_q + (ID_SIZE+1)'(alloc_fire) - (ID_SIZE+1)'(commit_fire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
      commit_addr  <= '0;
      commit_data  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[ID_SIZE'(i)] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
      if (commit_fire) begin
        commit_valid <= 1'b1;
        commit_we    <= entries_q[head_q].w;
        commit_addr  <= entries_q[head_q].addr;
        commit_data  <= entries_q[head_q].data;
      end else begin
        commit_valid <= 1'b0;
        commit_we    <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < N_LOOKUP; k++) begin : g_lookup
    rob_lookup #(
      .ID_SIZE          (ID_SIZE),
      .REG_ADDRESS_SIZE (REG_ADDRESS_SIZE),
      .REGISTER_SIZE    (REGISTER_SIZE)
    ) u_lookup (
      .entries (entries_q),
      .head    (head_q),
      .count   (count_q),
      .addr    (lk_addr[k*REG_ADDRESS_SIZE +: REG_ADDRESS_SIZE]),
      .hit     (lk_hit[k]),
      .ready   (lk_ready[k]),
      .id      (lk_id[k*ID_SIZE +: ID_SIZE]),
      .data    (lk_data[k*REGISTER_SIZE +: REGISTER_SIZE])
    );
  end

endmodule
